// File: rtl/sram_march_bist.sv
// March C- SRAM BIST: six elements, RD_LAT-deep compare pipe, first-fail capture.
// Define SRAM_BIST_CHECKERBOARD_EN for an address-dependent checkerboard background.
module sram_march_bist #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              BIST_start,
    output logic [ADDR_W-1:0] BIST_address,
    output logic [DATA_W-1:0] BIST_write_data,
    output logic              BIST_we_n,
    input  logic [DATA_W-1:0] BIST_read_data,
    output logic              BIST_finish,
    output logic              BIST_mismatch,
    output logic [15:0]       BIST_fail_count,
    output logic [ADDR_W-1:0] BIST_fail_address
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_M0    = 4'd1,
        S_M1    = 4'd2,
        S_M2    = 4'd3,
        S_M3    = 4'd4,
        S_M4    = 4'd5,
        S_M5    = 4'd6,
        S_DRAIN = 4'd7
    } state_t;

    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_MAX = '1;

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic              start_q, start_rise, start_clr;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              we_n_d, finish_d, wr_d1;
    logic [DATA_W-1:0] d0_nxt, d0_cur, exp_cur;
    logic              rd_now, rd_d1;

    logic [RD_LAT-1:0] pv_q;
    logic [DATA_W-1:0] pe_q [RD_LAT];
    logic [ADDR_W-1:0] pa_q [RD_LAT];
    logic              cmp_fail;

`ifdef SRAM_BIST_CHECKERBOARD_EN
    localparam logic [DATA_W-1:0] CB = {(DATA_W/2){2'b01}};
    assign d0_nxt = CB ^ {DATA_W{addr_d[0]}};
    assign d0_cur = CB ^ {DATA_W{BIST_address[0]}};
`else
    assign d0_nxt = '0;
    assign d0_cur = '0;
`endif

    assign start_rise = BIST_start & ~start_q;
    assign rd_now = BIST_we_n &&
        (state_q inside {S_M1, S_M2, S_M3, S_M4, S_M5});
    assign rd_d1   = (state_q == S_M2) || (state_q == S_M4);
    assign exp_cur = rd_d1 ? ~d0_cur : d0_cur;

    // state/addr/phase always describe the op currently on the bus
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        addr_d    = BIST_address;
        we_n_d    = 1'b1;
        wr_d1     = 1'b0;
        finish_d  = BIST_finish;
        start_clr = 1'b0;
        wdata_d   = BIST_write_data;
        unique case (state_q)
            S_IDLE: begin
                finish_d = 1'b1;
                if (start_rise) begin
                    state_d   = S_M0;
                    addr_d    = '0;
                    phase_d   = 1'b0;
                    we_n_d    = 1'b0;
                    finish_d  = 1'b0;
                    start_clr = 1'b1;
                end
            end
            S_M0: begin
                addr_d = BIST_address + A_ONE;
                if (BIST_address == A_MAX) state_d = S_M1;
                else we_n_d = 1'b0;
            end
            S_M1: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    we_n_d  = 1'b0;
                    wr_d1   = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    addr_d  = BIST_address + A_ONE;
                    if (BIST_address == A_MAX) state_d = S_M2;
                end
            end
            S_M2: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    we_n_d  = 1'b0;
                end else begin
                    phase_d = 1'b0;
                    if (BIST_address == A_MAX) state_d = S_M3;
                    else addr_d = BIST_address + A_ONE;
                end
            end
            S_M3: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    we_n_d  = 1'b0;
                    wr_d1   = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    addr_d  = BIST_address - A_ONE;
                    if (BIST_address == '0) state_d = S_M4;
                end
            end
            S_M4: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    we_n_d  = 1'b0;
                end else begin
                    phase_d = 1'b0;
                    if (BIST_address == '0) state_d = S_M5;
                    else addr_d = BIST_address - A_ONE;
                end
            end
            S_M5: begin
                if (BIST_address == A_MAX) state_d = S_DRAIN;
                else addr_d = BIST_address + A_ONE;
            end
            S_DRAIN: begin
                if (pv_q == '0) begin
                    state_d  = S_IDLE;
                    finish_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = 1'b0;
            end
        endcase
        if (!we_n_d) wdata_d = wr_d1 ? ~d0_nxt : d0_nxt;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q         <= S_IDLE;
            phase_q         <= 1'b0;
            start_q         <= 1'b0;
            BIST_address    <= '0;
            BIST_write_data <= '0;
            BIST_we_n       <= 1'b1;
            BIST_finish     <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            start_q         <= BIST_start;
            BIST_address    <= addr_d;
            BIST_write_data <= wdata_d;
            BIST_we_n       <= we_n_d;
            BIST_finish     <= finish_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= rd_now;
            for (int i = 1; i < RD_LAT; i++) pv_q[i] <= pv_q[i-1];
        end
    end

    always_ff @(posedge Clock) begin
        pe_q[0] <= exp_cur;
        pa_q[0] <= BIST_address;
        for (int i = 1; i < RD_LAT; i++) begin
            pe_q[i] <= pe_q[i-1];
            pa_q[i] <= pa_q[i-1];
        end
    end

    assign cmp_fail = pv_q[RD_LAT-1] &&
        (BIST_read_data != pe_q[RD_LAT-1]);

    always_ff @(posedge Clock) begin
        if (!Resetn || start_clr) begin
            BIST_mismatch     <= 1'b0;
            BIST_fail_count   <= '0;
            BIST_fail_address <= '0;
        end else if (cmp_fail) begin
            BIST_mismatch <= 1'b1;
            if (BIST_fail_count != 16'hFFFF)
                BIST_fail_count <= BIST_fail_count + 16'd1;
            if (BIST_fail_count == 16'd0)
                BIST_fail_address <= pa_q[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: table-driven and random SRAM faults against a march model.
// Build with SRAM_BIST_CHECKERBOARD_EN defined to exercise the RD_LAT=1 checkerboard variant.
module tb_sram_march_bist;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int N   = 16;
    localparam int OPS = 10 * N;
`ifdef SRAM_BIST_CHECKERBOARD_EN
    localparam int RL    = 1;
    localparam bit CB_EN = 1'b1;
`else
    localparam int RL    = 2;
    localparam bit CB_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we_n;
    logic [DW-1:0] rdata;
    logic          finish;
    logic          mm;
    logic [15:0]   fcnt;
    logic [AW-1:0] faddr;

    sram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .Clock            (clk),
        .Resetn           (rst_n),
        .BIST_start       (start),
        .BIST_address     (addr),
        .BIST_write_data  (wdata),
        .BIST_we_n        (we_n),
        .BIST_read_data   (rdata),
        .BIST_finish      (finish),
        .BIST_mismatch    (mm),
        .BIST_fail_count  (fcnt),
        .BIST_fail_address(faddr)
    );

    always #5 clk = ~clk;

    // fault: 0 none, 1 stuck bit (f_a addr, f_b bit, f_v value), 2 alias (write f_a also hits f_b)
    int f_kind = 0, f_a = 0, f_b = 0, f_v = 0;
    int checks = 0, errors = 0;
    int wr_count = 0;

    logic [DW-1:0] mem   [N];
    logic [DW-1:0] rpipe [RL];

    function automatic logic [DW-1:0] fread(input int a);
        logic [DW-1:0] v;
        v = mem[a];
        if (f_kind == 1 && a == f_a) v[f_b] = f_v[0];
        return v;
    endfunction

    always @(posedge clk) begin
        rpipe[0] <= fread(int'(addr));
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
        if (!we_n) begin
            mem[addr] <= wdata;
            if (f_kind == 2 && int'(addr) == f_a) mem[f_b] <= wdata;
            wr_count <= wr_count + 1;
        end
    end
    assign rdata = rpipe[RL-1];

    // reference march: flat list of every op the engine must issue
    bit            op_rd [OPS];
    int            op_a  [OPS];
    logic [DW-1:0] op_d  [OPS];
    int            n_ops;

    function automatic logic [DW-1:0] bg(input int a);
        if (!CB_EN) return 8'h00;
        return (a % 2 == 1) ? 8'hAA : 8'h55;
    endfunction

    task automatic add_op(input bit r, input int a, input logic [DW-1:0] d);
        op_rd[n_ops] = r;
        op_a[n_ops]  = a;
        op_d[n_ops]  = d;
        n_ops++;
    endtask

    task automatic build_ops();
        n_ops = 0;
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < N; j++) begin
                int a;
                a = (e == 3 || e == 4) ? N - 1 - j : j;
                case (e)
                    0: add_op(0, a, bg(a));
                    1: begin add_op(1, a, bg(a));  add_op(0, a, ~bg(a)); end
                    2: begin add_op(1, a, ~bg(a)); add_op(0, a, bg(a));  end
                    3: begin add_op(1, a, bg(a));  add_op(0, a, ~bg(a)); end
                    4: begin add_op(1, a, ~bg(a)); add_op(0, a, bg(a));  end
                    default: add_op(1, a, bg(a));
                endcase
            end
        end
    endtask

    task automatic predict(output int emm, output int ecnt, output int efa);
        logic [DW-1:0] m [N];
        logic [DW-1:0] v;
        ecnt = 0;
        efa  = 0;
        for (int i = 0; i < OPS; i++) begin
            if (!op_rd[i]) begin
                m[op_a[i]] = op_d[i];
                if (f_kind == 2 && op_a[i] == f_a) m[f_b] = op_d[i];
            end else begin
                v = m[op_a[i]];
                if (f_kind == 1 && op_a[i] == f_a) v[f_b] = f_v[0];
                if (v != op_d[i]) begin
                    if (ecnt == 0) efa = op_a[i];
                    ecnt++;
                end
            end
        end
        emm = (ecnt > 0) ? 1 : 0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " addr"}, int'(addr), 0);
        chk({nm, " wdata"}, int'(wdata), 0);
        chk({nm, " we_n"}, int'(we_n), 1);
        chk({nm, " finish"}, int'(finish), 0);
        chk({nm, " mismatch"}, int'(mm), 0);
        chk({nm, " count"}, int'(fcnt), 0);
        chk({nm, " fail_addr"}, int'(faddr), 0);
    endtask

    task automatic run_bist(input string nm, input int emm,
                            input int ecnt, input int efa);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        chk({nm, " idle finish"}, int'(finish), 1);
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < OPS; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                chk({nm, " finish low"}, int'(finish), 0);
            end
            if (i == 40) start = 1'b1;
            if (i == 41) start = 1'b0;
            if (we_n != op_rd[i] || int'(addr) != op_a[i] ||
                (!op_rd[i] && wdata != op_d[i])) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        if (bad != 0)
            $display("  %s first bad op %0d: addr %0d we_n %0b wdata %h",
                     nm, first, op_a[first], op_rd[first], op_d[first]);
        chk({nm, " op sequence errors"}, bad, 0);
        repeat (RL + 1) @(negedge clk);
        chk({nm, " finish early"}, int'(finish), 0);
        @(negedge clk);
        chk({nm, " finish"}, int'(finish), 1);
        chk({nm, " mismatch"}, int'(mm), emm);
        chk({nm, " count"}, int'(fcnt), ecnt);
        chk({nm, " fail_addr"}, int'(faddr), efa);
    endtask

    typedef struct {
        string name;
        int    kind;
        int    fa;
        int    fb;
        int    fv;
        int    emm;
        int    ecnt;
        int    efa;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int emm, ecnt, efa, falls, w0;
        bit prev;
        tbl[0] = '{"clean",        0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{"stuck5b0=1",   1, 5, 0, 1, 1, 3, 5};
        tbl[2] = '{"stuck2b7=0",   1, 2, 7, 0, 1, 2, 2};
        tbl[3] = '{"alias9to1",    2, 9, 1, 0, 1, 2, 1};
        build_ops();

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle finish after reset", int'(finish), 1);

        for (int r = 0; r < 4; r++) begin
            f_kind = tbl[r].kind;
            f_a    = tbl[r].fa;
            f_b    = tbl[r].fb;
            f_v    = tbl[r].fv;
            run_bist(tbl[r].name, tbl[r].emm, tbl[r].ecnt, tbl[r].efa);
        end

        for (int r = 0; r < 6; r++) begin
            f_kind = int'($urandom_range(1, 2));
            f_a    = int'($urandom_range(0, N - 1));
            if (f_kind == 1) begin
                f_b = int'($urandom_range(0, DW - 1));
                f_v = int'($urandom_range(0, 1));
            end else begin
                f_b = (f_a + int'($urandom_range(1, N - 1))) % N;
            end
            predict(emm, ecnt, efa);
            run_bist($sformatf("rand%0d", r), emm, ecnt, efa);
        end

        f_kind = 1; f_a = 5; f_b = 0; f_v = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5 * N + 3) @(negedge clk);
        chk("pre-reset mismatch", int'(mm), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("midrun reset");
        rst_n = 1'b1;
        w0 = wr_count;
        repeat (30) @(negedge clk);
        chk("writes after reset", wr_count - w0, 0);
        chk("finish after abort", int'(finish), 1);
        f_kind = 0;
        run_bist("post-abort clean", 0, 0, 0);

        f_kind = 1; f_a = 5; f_b = 0; f_v = 1;
        predict(emm, ecnt, efa);
        start = 1'b1;
        falls = 0;
        prev  = finish;
        repeat (500) begin
            @(negedge clk);
            if (prev && !finish) falls++;
            prev = finish;
        end
        chk("held start run count", falls, 1);
        chk("held start finish", int'(finish), 1);
        chk("held start count", int'(fcnt), ecnt);
        start  = 1'b0;
        f_kind = 0;
        @(negedge clk);
        run_bist("restart clears", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
